mem_port_arbiter: RTL and testbench

//  Shares the core's single memory port between instruction fetch (IF) and load/store (D).

---
 rtl/riscv_mem_pkg.sv | 23 ++
 rtl/mem_port_arbiter_rr_arb2.sv | 24 ++
 rtl/mem_port_arbiter.sv | 109 ++++++++++
 tb/tb_mem_port_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared types and helpers for the core's memory-port arbitration logic.
// Owner and FSM encodings plus a byte-enable constant generator.
package riscv_mem_pkg;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } arb_state_e;

  localparam int unsigned BeMaxBits = 64;

  // All-ones byte-enable mask for a data word of reg_bits bits, right-aligned.
  function automatic logic [BeMaxBits-1:0] be_all(input int unsigned reg_bits);
    if (reg_bits / 8 >= BeMaxBits) return '1;
    return (BeMaxBits'(1) << (reg_bits / 8)) - BeMaxBits'(1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the
// requester that did not win last. Purely combinational.
module rr_arb2
  import riscv_mem_pkg::*;
(
  input  logic [1:0] req,   // [0] = IF, [1] = D
  input  owner_e     last,
  output owner_e     sel,
  output logic       valid
);

  always_comb begin
    // NOTE: defaults first so every path assigns sel and valid; no latch.
    sel   = OWN_IF;
    valid = |req;
    case (req)
      2'b01:   sel = OWN_IF;
      2'b10:   sel = OWN_D;
      2'b11:   sel = (last == OWN_IF) ? OWN_D : OWN_IF;
      default: sel = OWN_IF;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store with
// round-robin arbitration and a single outstanding transaction.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned RegBits     = 32,
  parameter int unsigned MemAddrBits = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   if_req_i,
  input  logic [MemAddrBits-1:0] if_addr_i,
  output logic                   if_gnt_o,
  output logic                   if_rvalid_o,
  output logic [RegBits-1:0]     if_rdata_o,
  input  logic                   d_req_i,
  input  logic                   d_we_i,
  input  logic [RegBits/8-1:0]   d_be_i,
  input  logic [MemAddrBits-1:0] d_addr_i,
  input  logic [RegBits-1:0]     d_wdata_i,
  output logic                   d_gnt_o,
  output logic                   d_rvalid_o,
  output logic [RegBits-1:0]     d_rdata_o,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic [RegBits/8-1:0]   mem_be_o,
  output logic [MemAddrBits-1:0] mem_addr_o,
  output logic [RegBits-1:0]     mem_wdata_o,
  input  logic                   mem_gnt_i,
  input  logic                   mem_rvalid_i,
  input  logic [RegBits-1:0]     mem_rdata_i,
  output logic                   err_o
);

  localparam int unsigned            BeBits    = RegBits / 8;
  localparam logic [BeMaxBits-1:0]   BeAllWide = be_all(RegBits);
  localparam logic [BeBits-1:0]      BeAll     = BeAllWide[BeBits-1:0];

  arb_state_e state_q;
  owner_e     owner_q;
  owner_e     last_q;
  logic       err_q;

  owner_e sel;
  logic   sel_valid;
  logic   window;
  logic   grant;
  logic   resp;

  rr_arb2 u_rr_arb2 (
    .req   ({d_req_i, if_req_i}),
    .last  (last_q),
    .sel   (sel),
    .valid (sel_valid)
  );

  // A new request may issue when idle or in the cycle the current one completes.
  assign window    = (state_q == S_IDLE) | ((state_q == S_WAIT) & mem_rvalid_i);
  assign mem_req_o = ~rst_i & window & sel_valid;
  assign grant     = mem_req_o & mem_gnt_i;
  assign if_gnt_o  = grant & (sel == OWN_IF);
  assign d_gnt_o   = grant & (sel == OWN_D);

  assign resp        = ~rst_i & (state_q == S_WAIT) & mem_rvalid_i;
  assign if_rvalid_o = resp & (owner_q == OWN_IF);
  assign d_rvalid_o  = resp & (owner_q == OWN_D);
  assign if_rdata_o  = mem_rdata_i;
  assign d_rdata_o   = mem_rdata_i;
  assign err_o       = err_q;

  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (mem_req_o) begin
      if (sel == OWN_IF) begin
        mem_be_o   = BeAll;
        mem_addr_o = if_addr_i;
      end else begin
        mem_we_o    = d_we_i;
        mem_be_o    = d_be_i;
        mem_addr_o  = d_addr_i;
        mem_wdata_o = d_wdata_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      state_q <= S_IDLE;
      owner_q <= OWN_IF;
      last_q  <= OWN_D;
      err_q   <= 1'b0;
    end else begin
      if (grant) begin
        state_q <= S_WAIT;
        owner_q <= sel;
        last_q  <= sel;
      end else if (resp) begin
        state_q <= S_IDLE;
      end
      // A response with nothing outstanding is dropped and flagged for good.
      if ((state_q == S_IDLE) && mem_rvalid_i) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic, with
// a transaction-level reference and a read-data scoreboard.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        d_req_i, d_we_i;
  logic [3:0]  d_be_i;
  logic [31:0] d_addr_i, d_wdata_i;
  logic        d_gnt_o, d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        err_o;

  mem_port_arbiter #(.RegBits(32), .MemAddrBits(32)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o),
    .d_rdata_o(d_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .err_o(err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Knobs shared by the stimulus processes.
  logic manual    = 1'b1;
  int   if_rate   = 0;
  int   d_rate    = 0;
  int   gnt_force = 1;  // 0 random, 1 always ready, 2 stalled
  int   lat_fixed = 1;  // 0 random 1..4
  logic inject    = 1'b0;
  logic if_gnt_seen = 1'b0;
  logic d_gnt_seen  = 1'b0;

  // Two word memories: one written from the requester side at grant time
  // (reference), one from the memory pins at acceptance (device).
  logic [31:0] ref_mem [logic [29:0]];
  logic [31:0] dev_mem [logic [29:0]];

  function automatic logic [31:0] init_word(input logic [29:0] k);
    return {k, 2'b01} * 32'h9E37_79B1;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be,
                                        input logic [31:0] d);
    logic [31:0] w;
    w = old;
    for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
    return w;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [29:0] k);
    return ref_mem.exists(k) ? ref_mem[k] : init_word(k);
  endfunction

  function automatic logic [31:0] dev_rd(input logic [29:0] k);
    return dev_mem.exists(k) ? dev_mem[k] : init_word(k);
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'h1000 + 32'($urandom_range(0, 15)) * 4;
  endfunction

  typedef struct {
    logic        is_wr;
    logic [31:0] data;
  } exp_t;
  exp_t if_q[$];
  exp_t d_q[$];

  initial begin
    rst_i = 1'b1; if_req_i = 1'b0; if_addr_i = '0;
    d_req_i = 1'b0; d_we_i = 1'b0; d_be_i = '0; d_addr_i = '0; d_wdata_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
  end

  // Fetch requester: holds address until granted, then may issue again.
  initial forever begin
    @(posedge clk); #1;
    if (!manual) begin
      if (rst_i) if_req_i = 1'b0;
      else begin
        if (if_req_i && if_gnt_seen) if_req_i = 1'b0;
        if (!if_req_i && ($urandom_range(0, 99) < if_rate)) begin
          if_addr_i = rand_addr();
          if_req_i  = 1'b1;
        end
      end
    end
    if_gnt_seen = 1'b0;
  end

  // Load/store requester.
  initial forever begin
    @(posedge clk); #1;
    if (!manual) begin
      if (rst_i) d_req_i = 1'b0;
      else begin
        if (d_req_i && d_gnt_seen) d_req_i = 1'b0;
        if (!d_req_i && ($urandom_range(0, 99) < d_rate)) begin
          d_we_i    = 1'($urandom_range(0, 1));
          d_be_i    = 4'($urandom_range(1, 15));
          d_addr_i  = rand_addr();
          d_wdata_i = $urandom;
          d_req_i   = 1'b1;
        end
      end
    end
    d_gnt_seen = 1'b0;
  end

  // Issue side: each granted request pushes its expected response.
  always @(negedge clk) begin
    if (rst_i) begin
      if_q.delete();
      d_q.delete();
    end else begin
      if (if_gnt_o) begin
        if_q.push_back('{is_wr: 1'b0, data: ref_rd(if_addr_i[31:2])});
        if_gnt_seen = 1'b1;
      end
      if (d_gnt_o) begin
        if (d_we_i) begin
          ref_mem[d_addr_i[31:2]] = merge(ref_rd(d_addr_i[31:2]), d_be_i, d_wdata_i);
          d_q.push_back('{is_wr: 1'b1, data: 32'h0});
        end else begin
          d_q.push_back('{is_wr: 1'b0, data: ref_rd(d_addr_i[31:2])});
        end
        d_gnt_seen = 1'b1;
      end
    end
  end

  // Memory model: accepts on req&gnt, answers after a latency of >= 1 cycle.
  int          cyc = 0;
  logic        pend = 1'b0;
  int          resp_cyc = 0;
  logic [31:0] resp_dat = '0;

  always @(negedge clk) begin
    if (rst_i) pend = 1'b0;
    else begin
      if (pend && mem_rvalid_i && (cyc == resp_cyc)) pend = 1'b0;
      if (mem_req_o && mem_gnt_i) begin
        check("mem_overlap", pend, 1'b0);
        if (mem_we_o) begin
          dev_mem[mem_addr_o[31:2]] = merge(dev_rd(mem_addr_o[31:2]), mem_be_o, mem_wdata_o);
          resp_dat = $urandom;
        end else begin
          resp_dat = dev_rd(mem_addr_o[31:2]);
        end
        pend     = 1'b1;
        resp_cyc = cyc + ((lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 4)));
      end
    end
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
    #1;
    mem_rvalid_i = (pend && (cyc == resp_cyc)) || inject;
    mem_rdata_i  = (pend && (cyc == resp_cyc)) ? resp_dat : $urandom;
    inject       = 1'b0;
    mem_gnt_i    = (gnt_force == 1) ? 1'b1 :
                   (gnt_force == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor: transaction-level reference of the arbitration rules.
  int          outstanding = 0;
  logic        own_d = 1'b0;
  logic        last_d = 1'b1;
  logic        exp_err = 1'b0;
  logic        m_rsp, m_req, m_sel_d, m_ig, m_dg;
  logic [68:0] m_pl;
  exp_t        m_e;

  always @(negedge clk) begin
    if (rst_i) begin
      check("rst_quiet", {mem_req_o, if_gnt_o, d_gnt_o, if_rvalid_o, d_rvalid_o}, 5'b0);
      outstanding = 0;
      last_d      = 1'b1;
      exp_err     = 1'b0;
    end else begin
      check("err", err_o, exp_err);
      m_rsp   = (outstanding != 0) && mem_rvalid_i;
      m_req   = ((outstanding == 0) || mem_rvalid_i) && (if_req_i || d_req_i);
      m_sel_d = (if_req_i && d_req_i) ? !last_d : d_req_i;
      m_ig    = m_req && mem_gnt_i && !m_sel_d;
      m_dg    = m_req && mem_gnt_i && m_sel_d;
      check("mem_req", mem_req_o, m_req);
      check("grants", {if_gnt_o, d_gnt_o}, {m_ig, m_dg});
      if (!m_req)       m_pl = '0;
      else if (m_sel_d) m_pl = {d_we_i, d_be_i, d_addr_i, d_wdata_i};
      else              m_pl = {1'b0, 4'hf, if_addr_i, 32'h0};
      check("payload", {mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}, m_pl);
      check("rvalids", {if_rvalid_o, d_rvalid_o}, {m_rsp && !own_d, m_rsp && own_d});
      if (if_rvalid_o) begin
        check("if_resp_expected", if_q.size() != 0, 1'b1);
        if (if_q.size() != 0) begin
          m_e = if_q.pop_front();
          check("if_rdata", if_rdata_o, m_e.data);
        end
      end
      if (d_rvalid_o) begin
        check("d_resp_expected", d_q.size() != 0, 1'b1);
        if (d_q.size() != 0) begin
          m_e = d_q.pop_front();
          if (!m_e.is_wr) check("d_rdata", d_rdata_o, m_e.data);
        end
      end
      if ((outstanding == 0) && mem_rvalid_i) exp_err = 1'b1;
      if (m_rsp) outstanding = 0;
      if (m_ig || m_dg) begin
        outstanding = 1;
        own_d       = m_sel_d;
        last_d      = m_sel_d;
      end
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  logic seen;

  initial begin
    ref_mem[30'h40] = 32'hDEAD_BEEF;
    dev_mem[30'h40] = 32'hDEAD_BEEF;
    repeat (3) step();
    rst_i = 1'b0;
    at_neg();
    check("reset_err", err_o, 1'b0);
    check("reset_req", mem_req_o, 1'b0);

    // Uncontended fetch, 1-cycle memory.
    step(); if_req_i = 1'b1; if_addr_i = 32'h100;
    at_neg(); check("t1_gnt", if_gnt_o, 1'b1);
    step(); if_req_i = 1'b0;
    at_neg(); check("t1_rvalid", if_rvalid_o, 1'b1);
    check("t1_rdata", if_rdata_o, 32'hDEAD_BEEF);
    repeat (4) at_neg();

    // Stalled data write.
    gnt_force = 2;
    step(); d_req_i = 1'b1; d_we_i = 1'b1; d_be_i = 4'b0011;
    d_addr_i = 32'h200; d_wdata_i = 32'h1234;
    for (int k = 0; k < 3; k++) begin
      at_neg();
      check("t3_req", mem_req_o, 1'b1);
      check("t3_payload", {mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o},
            {1'b1, 4'b0011, 32'h200, 32'h1234});
      check("t3_no_gnt", d_gnt_o, 1'b0);
    end
    gnt_force = 1;
    step();
    at_neg(); check("t3_gnt", d_gnt_o, 1'b1);
    step(); d_req_i = 1'b0;
    at_neg(); check("t3_ack", d_rvalid_o, 1'b1);
    repeat (4) at_neg();

    // 3-cycle memory: pending D is granted in the IF response cycle.
    lat_fixed = 3;
    step(); if_req_i = 1'b1; if_addr_i = 32'h80;
    at_neg(); check("t6_if_gnt", if_gnt_o, 1'b1);
    step(); if_req_i = 1'b0;
    d_req_i = 1'b1; d_we_i = 1'b0; d_be_i = 4'hf; d_addr_i = 32'h84; d_wdata_i = '0;
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      at_neg();
      seen = if_rvalid_o;
    end
    check("t6_rv_seen", seen, 1'b1);
    check("t6_d_gnt", d_gnt_o, 1'b1);
    step(); d_req_i = 1'b0;
    repeat (6) at_neg();

    // Response while idle.
    inject = 1'b1;
    step();
    at_neg();
    check("t4_no_rvalid", {if_rvalid_o, d_rvalid_o}, 2'b00);
    check("t4_err_pre", err_o, 1'b0);
    at_neg(); check("t4_err_set", err_o, 1'b1);
    repeat (4) at_neg();
    check("t4_err_sticky", err_o, 1'b1);

    // Reset in the middle of a transaction.
    lat_fixed = 5;
    step(); if_req_i = 1'b1; if_addr_i = 32'h40;
    at_neg(); check("t5_if_gnt", if_gnt_o, 1'b1);
    step(); if_req_i = 1'b0;
    at_neg();
    step(); rst_i = 1'b1; if_req_i = 1'b1; d_req_i = 1'b1;
    d_we_i = 1'b0; d_be_i = 4'hf; d_addr_i = 32'h44;
    at_neg();
    step();
    at_neg();
    check("t5_quiet", {mem_req_o, if_gnt_o, d_gnt_o, if_rvalid_o, d_rvalid_o}, 5'b0);
    check("t5_err_clr", err_o, 1'b0);
    step(); rst_i = 1'b0;
    at_neg(); check("t5_tie", {if_gnt_o, d_gnt_o}, 2'b10);
    step(); if_req_i = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      at_neg();
      seen = d_gnt_o;
    end
    check("t5_d_gnt", seen, 1'b1);
    step(); d_req_i = 1'b0;
    repeat (8) at_neg();

    // Both requesting continuously with 1-cycle memory.
    lat_fixed = 1;
    step(); rst_i = 1'b1;
    step(); rst_i = 1'b0; if_rate = 100; d_rate = 100; manual = 1'b0;
    at_neg();
    for (int i = 0; i < 16; i++) begin
      at_neg();
      check("t2_alternate", {if_gnt_o, d_gnt_o}, (i % 2 == 0) ? 2'b10 : 2'b01);
    end

    // Randomized traffic.
    gnt_force = 0;
    lat_fixed = 0;
    for (int s = 0; s < 6; s++) begin
      if_rate = $urandom_range(10, 100);
      d_rate  = $urandom_range(10, 100);
      repeat (500) at_neg();
    end

    if_rate = 0;
    d_rate  = 0;
    repeat (40) at_neg();
    check("drain_reqs", {if_req_i, d_req_i}, 2'b00);
    check("drain_if_q", if_q.size(), 0);
    check("drain_d_q", d_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
